// File: rtl/smg_decode_capture_pkg.sv
// Shared constants and types for the 7-segment scan-bus capture monitor.
// Segment codes are active low, bit order g..a; the encoder side uses the same table.
package smg_decode_capture_pkg;

  localparam int unsigned SegW  = 8;
  localparam int unsigned DpBit = 7;
  localparam int unsigned CntW  = 4;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Result of decoding one segment pattern.
  typedef struct packed {
    logic       hit;    // legal hex glyph
    logic       blank;  // all segments off
    logic [3:0] value;
  } seg_dec_t;

  // Stability counter increment that stops at the commit threshold.
  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] cnt,
                                              input logic [CntW-1:0] lim);
    sat_inc = (cnt >= lim) ? lim : cnt + CntW'(1);
  endfunction

endpackage

// File: rtl/smg_decode_capture_if.sv
// Scan-bus observation interface: raw scan inputs plus the committed digit outputs.
interface smg_decode_capture_if #(
  parameter int unsigned Digits = 6
);
  logic [7:0]          seg_i;
  logic [Digits-1:0]   sel_i;
  logic [4*Digits-1:0] data_o;
  logic [Digits-1:0]   valid_o;
  logic [Digits-1:0]   dp_o;
  logic                err_o;
  logic                frame_o;

  // Scan driver / testbench side.
  modport master (
    output seg_i, sel_i,
    input  data_o, valid_o, dp_o, err_o, frame_o
  );

  // Monitor side.
  modport slave (
    input  seg_i, sel_i,
    output data_o, valid_o, dp_o, err_o, frame_o
  );
endinterface

// File: rtl/smg_decode_immdmod.sv
// Combinational decode of an active-low 7-segment pattern back to its hex value.
module smg_decode_immdmod
  import smg_decode_capture_pkg::*;
(
  input  logic [6:0] seg_i,
  output seg_dec_t   dec_o
);

  // Table lookup; anything not in the glyph set or blank is illegal.
  always_comb begin
    dec_o = '{hit: 1'b1, blank: 1'b0, value: 4'h0};
    case (seg_i)
      SEG_0:     dec_o.value = 4'h0;
      SEG_1:     dec_o.value = 4'h1;
      SEG_2:     dec_o.value = 4'h2;
      SEG_3:     dec_o.value = 4'h3;
      SEG_4:     dec_o.value = 4'h4;
      SEG_5:     dec_o.value = 4'h5;
      SEG_6:     dec_o.value = 4'h6;
      SEG_7:     dec_o.value = 4'h7;
      SEG_8:     dec_o.value = 4'h8;
      SEG_9:     dec_o.value = 4'h9;
      SEG_A:     dec_o.value = 4'hA;
      SEG_B:     dec_o.value = 4'hB;
      SEG_C:     dec_o.value = 4'hC;
      SEG_D:     dec_o.value = 4'hD;
      SEG_E:     dec_o.value = 4'hE;
      SEG_F:     dec_o.value = 4'hF;
      SEG_BLANK: begin
        dec_o.hit   = 1'b0;
        dec_o.blank = 1'b1;
      end
      default:   dec_o.hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/smg_decode_capture.sv
// Scan-bus self-test monitor: tracks digit-select runs, decodes the last pattern of each
// run and commits a digit once the same code has been seen on consecutive visits.
module smg_decode_capture
  import smg_decode_capture_pkg::*;
#(
  parameter int unsigned Digits      = 6,
  parameter int unsigned StableScans = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  smg_decode_capture_if.slave  bus
);

  localparam int unsigned IdxW = (Digits > 1) ? $clog2(Digits) : 1;
  localparam logic [CntW-1:0] StableCnt = CntW'(StableScans);

  // Run tracker state.
  logic [Digits-1:0] sel_q;
  logic              run_open_q;
  logic [IdxW-1:0]   run_idx_q;
  logic [SegW-1:0]   seg_q;

  // Per-digit candidate {value, dp}, stability count and committed outputs.
  logic [Digits-1:0][4:0]      cand_q, cand_d;
  logic [Digits-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [Digits-1:0][3:0]      data_q, data_d;
  logic [Digits-1:0]           valid_q, valid_d;
  logic [Digits-1:0]           dp_q, dp_d;
  logic [Digits-1:0]           visited_q, visited_d;
  logic                        err_q, err_d;
  logic                        frame_q, frame_d;

  logic [IdxW:0]   low_cnt;
  logic [IdxW-1:0] low_idx;
  logic            sel_one;
  logic            sel_multi;
  logic            sel_change;
  logic            run_end;
  logic            run_dp;
  seg_dec_t        dec;

  // Classify the current select: how many bits are low and which one.
  always_comb begin
    low_cnt = '0;
    low_idx = '0;
    for (int i = 0; i < Digits; i++) begin
      if (!bus.sel_i[i]) begin
        low_cnt = low_cnt + (IdxW + 1)'(1);
        low_idx = IdxW'(i);
      end
    end
  end

  assign sel_one    = (low_cnt == (IdxW + 1)'(1));
  assign sel_multi  = (low_cnt > (IdxW + 1)'(1));
  assign sel_change = (bus.sel_i != sel_q);
  assign run_end    = run_open_q && sel_change;
  assign run_dp     = ~seg_q[DpBit];

  smg_decode_immdmod u_dec (
    .seg_i (seg_q[6:0]),
    .dec_o (dec)
  );

  // Register the select and, while a single digit is selected, the latest pattern so the
  // decode at run end sees the final cycle rather than a ghost from the transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q      <= '1;
      run_open_q <= 1'b0;
      run_idx_q  <= '0;
      seg_q      <= '1;
    end else begin
      sel_q      <= bus.sel_i;
      run_open_q <= sel_one;
      if (sel_one) begin
        run_idx_q <= low_idx;
        seg_q     <= bus.seg_i;
      end
    end
  end

  // Closed-run decode, candidate/count update, commit and frame mask bookkeeping.
  always_comb begin
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    dp_d      = dp_q;
    visited_d = visited_q;
    err_d     = sel_multi && sel_change;
    frame_d   = 1'b0;

    if (run_end) begin
      visited_d[run_idx_q] = 1'b1;
      if (dec.blank) begin
        valid_d[run_idx_q] = 1'b0;
        cnt_d[run_idx_q]   = '0;
      end else if (!dec.hit) begin
        err_d            = 1'b1;
        cnt_d[run_idx_q] = '0;
      end else begin
        if ({dec.value, run_dp} == cand_q[run_idx_q]) begin
          cnt_d[run_idx_q] = sat_inc(cnt_q[run_idx_q], StableCnt);
        end else begin
          cand_d[run_idx_q] = {dec.value, run_dp};
          cnt_d[run_idx_q]  = CntW'(1);
        end
        if (cnt_d[run_idx_q] == StableCnt) begin
          data_d[run_idx_q]  = dec.value;
          dp_d[run_idx_q]    = run_dp;
          valid_d[run_idx_q] = 1'b1;
        end
      end
      // Mask clears in the same cycle it fills so the next frame starts fresh.
      if (&visited_d) begin
        frame_d   = 1'b1;
        visited_d = '0;
      end
    end
  end

  // Per-digit state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q    <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      valid_q   <= '0;
      dp_q      <= '0;
      visited_q <= '0;
      err_q     <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      dp_q      <= dp_d;
      visited_q <= visited_d;
      err_q     <= err_d;
      frame_q   <= frame_d;
    end
  end

  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.dp_o    = dp_q;
  assign bus.err_o   = err_q;
  assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_smg_decode_capture.sv
// Self-checking bench for smg_decode_capture: a reference model pushes the expected
// outputs for each driven cycle, and a monitor compares them one clock later.
module tb_smg_decode_capture;

  localparam int Digits = 6;
  localparam int Stable = 2;
  localparam logic [5:0] Idle = 6'h3F;

  typedef struct {
    logic [23:0] data;
    logic [5:0]  valid;
    logic [5:0]  dp;
    logic        err;
    logic        frame;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   err_seen;
  int   frame_seen;
  int   cyc;
  exp_t sb_q[$];

  // Reference tables and model state.
  logic [6:0] segtab [16];
  logic [5:0] m_prev_sel;
  logic       m_open;
  int         m_idx;
  logic [7:0] m_seg;
  int         m_cand [Digits];
  logic       m_cdp [Digits];
  int         m_cnt [Digits];
  logic [23:0] m_data;
  logic [5:0]  m_valid;
  logic [5:0]  m_dp;
  logic [5:0]  m_visit;

  smg_decode_capture_if #(.Digits(Digits)) bus ();

  smg_decode_capture #(
    .Digits      (Digits),
    .StableScans (Stable)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    segtab[0] = 7'h40;  segtab[1] = 7'h79;  segtab[2] = 7'h24;  segtab[3] = 7'h30;
    segtab[4] = 7'h19;  segtab[5] = 7'h12;  segtab[6] = 7'h02;  segtab[7] = 7'h78;
    segtab[8] = 7'h00;  segtab[9] = 7'h10;  segtab[10] = 7'h08; segtab[11] = 7'h03;
    segtab[12] = 7'h46; segtab[13] = 7'h21; segtab[14] = 7'h06; segtab[15] = 7'h0E;
  end

  // Returns 0..15 for a glyph, 16 for blank, -1 for an illegal pattern.
  function automatic int ref_decode(input logic [6:0] s);
    ref_decode = -1;
    if (s == 7'h7F) ref_decode = 16;
    for (int i = 0; i < 16; i++) if (segtab[i] == s) ref_decode = i;
  endfunction

  function automatic int zeros(input logic [5:0] s);
    zeros = 0;
    for (int i = 0; i < Digits; i++) if (!s[i]) zeros++;
  endfunction

  function automatic int low_index(input logic [5:0] s);
    low_index = 0;
    for (int i = 0; i < Digits; i++) if (!s[i]) low_index = i;
  endfunction

  task automatic model_reset();
    m_prev_sel = Idle;
    m_open     = 1'b0;
    m_idx      = 0;
    m_seg      = 8'hFF;
    m_data     = '0;
    m_valid    = '0;
    m_dp       = '0;
    m_visit    = '0;
    for (int k = 0; k < Digits; k++) begin
      m_cand[k] = 0;
      m_cdp[k]  = 1'b0;
      m_cnt[k]  = 0;
    end
  endtask

  // Drive one cycle of scan-bus input and queue the outputs expected after the next edge.
  task automatic drive(input logic [7:0] seg, input logic [5:0] sel);
    exp_t e;
    int   code;
    logic dpv;
    @(negedge clk);
    bus.seg_i = seg;
    bus.sel_i = sel;
    e.err   = 1'b0;
    e.frame = 1'b0;
    if (m_open && sel != m_prev_sel) begin
      code = ref_decode(m_seg[6:0]);
      dpv  = ~m_seg[7];
      m_visit[m_idx] = 1'b1;
      if (code == 16) begin
        m_valid[m_idx] = 1'b0;
        m_cnt[m_idx]   = 0;
      end else if (code < 0) begin
        e.err        = 1'b1;
        m_cnt[m_idx] = 0;
      end else begin
        if (m_cand[m_idx] == code && m_cdp[m_idx] == dpv) begin
          if (m_cnt[m_idx] < Stable) m_cnt[m_idx]++;
        end else begin
          m_cand[m_idx] = code;
          m_cdp[m_idx]  = dpv;
          m_cnt[m_idx]  = 1;
        end
        if (m_cnt[m_idx] == Stable) begin
          m_data[m_idx*4 +: 4] = code[3:0];
          m_dp[m_idx]          = dpv;
          m_valid[m_idx]       = 1'b1;
        end
      end
      if (m_visit == Idle) begin
        e.frame = 1'b1;
        m_visit = '0;
      end
    end
    if (zeros(sel) > 1 && sel != m_prev_sel) e.err = 1'b1;
    m_open = (zeros(sel) == 1);
    if (m_open) begin
      m_idx = low_index(sel);
      m_seg = seg;
    end
    m_prev_sel = sel;
    e.data  = m_data;
    e.valid = m_valid;
    e.dp    = m_dp;
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Select digit k for n cycles, then one idle cycle to close the run.
  task automatic visit(input int k, input logic [7:0] seg, input int n);
    logic [5:0] sel;
    sel = Idle;
    sel[k] = 1'b0;
    for (int i = 0; i < n; i++) drive(seg, sel);
    drive(8'hFF, Idle);
  endtask

  task automatic scan_frame(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                            input logic [7:0] p3, input logic [7:0] p4, input logic [7:0] p5);
    logic [7:0] pat [6];
    logic [5:0] sel;
    pat[0] = p0; pat[1] = p1; pat[2] = p2; pat[3] = p3; pat[4] = p4; pat[5] = p5;
    for (int k = 0; k < Digits; k++) begin
      sel = Idle;
      sel[k] = 1'b0;
      for (int i = 0; i < 4; i++) drive(pat[k], sel);
    end
  endtask

  // Scoreboard: compare every queued expectation one clock after it was driven.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.err_o === 1'b1) err_seen++;
      if (bus.frame_o === 1'b1) frame_seen++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (bus.data_o !== e.data) begin
          errors++;
          $display("FAIL data cyc=%0d got=%h exp=%h", cyc, bus.data_o, e.data);
        end
        checks++;
        if (bus.valid_o !== e.valid) begin
          errors++;
          $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, bus.valid_o, e.valid);
        end
        checks++;
        if (bus.dp_o !== e.dp) begin
          errors++;
          $display("FAIL dp cyc=%0d got=%b exp=%b", cyc, bus.dp_o, e.dp);
        end
        checks++;
        if (bus.err_o !== e.err) begin
          errors++;
          $display("FAIL err cyc=%0d got=%b exp=%b", cyc, bus.err_o, e.err);
        end
        checks++;
        if (bus.frame_o !== e.frame) begin
          errors++;
          $display("FAIL frame cyc=%0d got=%b exp=%b", cyc, bus.frame_o, e.frame);
        end
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    checks++;
    if (bus.data_o !== '0 || bus.valid_o !== '0 || bus.dp_o !== '0 ||
        bus.err_o !== 1'b0 || bus.frame_o !== 1'b0) begin
      errors++;
      $display("FAIL %s got data=%h valid=%b dp=%b err=%b frame=%b exp all zero", tag,
               bus.data_o, bus.valid_o, bus.dp_o, bus.err_o, bus.frame_o);
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.seg_i = 8'hFF;
    bus.sel_i = Idle;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset_por");
    rst = 1'b0;
  endtask

  task automatic test_scan();
    int f0;
    int e0;
    f0 = frame_seen;
    e0 = err_seen;
    scan_frame(8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12);
    drive(8'hFF, Idle);
    checks++;
    if (bus.valid_o !== 6'h00) begin
      errors++;
      $display("FAIL scan_valid_first got=%b exp=000000", bus.valid_o);
    end
    scan_frame(8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12);
    drive(8'hFF, Idle);
    checks++;
    if (bus.data_o !== 24'h543210 || bus.valid_o !== 6'h3F) begin
      errors++;
      $display("FAIL scan_commit got data=%h valid=%b exp 543210/111111", bus.data_o,
               bus.valid_o);
    end
    checks++;
    if (frame_seen - f0 != 2 || err_seen != e0) begin
      errors++;
      $display("FAIL scan_pulses got frames=%0d errs=%0d exp 2/0", frame_seen - f0,
               err_seen - e0);
    end
  endtask

  task automatic test_reset_midrun();
    drive(8'h30, 6'b110111);
    drive(8'h30, 6'b110111);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero_outputs("reset_midrun");
    bus.seg_i = 8'hFF;
    bus.sel_i = Idle;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    scan_frame(8'h40, 8'h79, 8'h30, 8'h30, 8'h19, 8'h12);
    drive(8'hFF, Idle);
    checks++;
    if (bus.valid_o !== 6'h00) begin
      errors++;
      $display("FAIL reset_no_early_valid got=%b exp=000000", bus.valid_o);
    end
    scan_frame(8'h40, 8'h79, 8'h30, 8'h30, 8'h19, 8'h12);
    drive(8'hFF, Idle);
    checks++;
    if (bus.data_o !== 24'h543310 || bus.valid_o !== 6'h3F) begin
      errors++;
      $display("FAIL reset_recommit got data=%h valid=%b exp 543310/111111", bus.data_o,
               bus.valid_o);
    end
  endtask

  task automatic test_digit_change();
    visit(2, 8'h78, 4);
    checks++;
    if (bus.data_o[11:8] !== 4'h3) begin
      errors++;
      $display("FAIL change_first got=%h exp=3", bus.data_o[11:8]);
    end
    visit(2, 8'h78, 4);
    checks++;
    if (bus.data_o[11:8] !== 4'h7) begin
      errors++;
      $display("FAIL change_second got=%h exp=7", bus.data_o[11:8]);
    end
  endtask

  task automatic test_illegal();
    int e0;
    e0 = err_seen;
    visit(0, 8'h55, 4);
    checks++;
    if (err_seen - e0 != 1 || bus.data_o[3:0] !== 4'h0 || bus.valid_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL illegal got errs=%0d d0=%h v0=%b exp 1/0/1", err_seen - e0,
               bus.data_o[3:0], bus.valid_o[0]);
    end
    visit(0, 8'h40, 2);
    visit(0, 8'h40, 2);
    checks++;
    if (bus.data_o[3:0] !== 4'h0 || bus.valid_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL illegal_recommit got d0=%h v0=%b exp 0/1", bus.data_o[3:0],
               bus.valid_o[0]);
    end
  endtask

  task automatic test_multi_blank();
    int e0;
    logic [23:0] d0;
    e0 = err_seen;
    d0 = bus.data_o;
    drive(8'h40, 6'b111100);
    drive(8'hFF, Idle);
    checks++;
    if (err_seen - e0 != 1 || bus.data_o !== d0) begin
      errors++;
      $display("FAIL multi_low got errs=%0d data=%h exp 1/%h", err_seen - e0, bus.data_o, d0);
    end
    e0 = err_seen;
    visit(5, 8'hFF, 3);
    checks++;
    if (bus.valid_o[5] !== 1'b0 || err_seen != e0 || bus.data_o[23:20] !== 4'h5) begin
      errors++;
      $display("FAIL blank got v5=%b errs=%0d d5=%h exp 0/0/5", bus.valid_o[5],
               err_seen - e0, bus.data_o[23:20]);
    end
  endtask

  task automatic test_back_to_back();
    drive(8'h00, 6'b111110);
    drive(8'h40, 6'b111101);
    drive(8'h00, 6'b111110);
    drive(8'h40, 6'b111101);
    drive(8'hFF, Idle);
    checks++;
    if (bus.data_o[7:0] !== 8'h08 || bus.dp_o[0] !== 1'b1 || bus.valid_o[1:0] !== 2'b11) begin
      errors++;
      $display("FAIL back_to_back got d=%h dp0=%b v=%b exp 08/1/11", bus.data_o[7:0],
               bus.dp_o[0], bus.valid_o[1:0]);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    err_seen   = 0;
    frame_seen = 0;
    cyc        = 0;
    test_reset();
    test_scan();
    test_reset_midrun();
    test_digit_change();
    test_illegal();
    test_multi_blank();
    test_back_to_back();
    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
